// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; 33-cycle latency, Start ignored while busy.
// SEQ_DIVIDER_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC for a 1-cycle latency.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } divState;

  localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  divState          state;
  divState          nextState;
  logic [5:0]       iterCnt;
  logic [WIDTH:0]   remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divsReg;
  logic [WIDTH-1:0] dividendOrig;
  logic             qNeg;
  logic             rNeg;
  logic             divZero;
  logic             overflow;

  // Operand conditioning on the acceptance edge
  logic             accept;
  logic             dividendNeg;
  logic             divisorNeg;
  logic [WIDTH-1:0] absDividend;
  logic [WIDTH-1:0] absDivisor;
  logic             divZeroIn;
  logic             overflowIn;

  assign accept      = (state == IDLE) && Start;
  assign dividendNeg = Signed && Dividend[WIDTH-1];
  assign divisorNeg  = Signed && Divisor[WIDTH-1];
  assign absDividend = dividendNeg ? -Dividend : Dividend;
  assign absDivisor  = divisorNeg ? -Divisor : Divisor;
  assign divZeroIn   = (Divisor == '0);
  assign overflowIn  = Signed && (Dividend == MIN_NEG) && (&Divisor);

  // One restoring step: the borrow out of the WIDTH+1-bit trial decides the quotient bit
  logic [WIDTH:0]   shiftedRem;
  logic [WIDTH:0]   trialRem;
  logic             trialOk;
  logic [WIDTH:0]   stepRem;
  logic [WIDTH-1:0] stepQuo;

  assign shiftedRem = {remReg[WIDTH-1:0], quoReg[WIDTH-1]};
  assign trialRem   = shiftedRem - {1'b0, divsReg};
  assign trialOk    = ~trialRem[WIDTH];
  assign stepRem    = trialOk ? trialRem : shiftedRem;
  assign stepQuo    = {quoReg[WIDTH-2:0], trialOk};

  // Final result selection, including the RISC-V special-case overrides
  logic [WIDTH-1:0] fixQuo;
  logic [WIDTH-1:0] fixRem;

  always_comb begin
    fixQuo = qNeg ? -quoReg : quoReg;
    fixRem = rNeg ? -remReg[WIDTH-1:0] : remReg[WIDTH-1:0];
    if (divZero) begin
      fixQuo = '1;
      fixRem = dividendOrig;
    end else if (overflow) begin
      fixQuo = MIN_NEG;
      fixRem = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
          nextState = (divZeroIn || overflowIn) ? FIX : CALC;
`else
          nextState = CALC;
`endif
        end
      end
      CALC: begin
        busy = 1'b1;
        if (iterCnt == LAST_ITER) begin
          nextState = FIX;
        end
      end
      FIX: begin
        busy      = 1'b1;
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      iterCnt      <= '0;
      remReg       <= '0;
      quoReg       <= '0;
      divsReg      <= '0;
      dividendOrig <= '0;
      qNeg         <= 1'b0;
      rNeg         <= 1'b0;
      divZero      <= 1'b0;
      overflow     <= 1'b0;
      Quotient     <= '0;
      Remainder    <= '0;
      done         <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept) begin
            iterCnt      <= '0;
            remReg       <= '0;
            quoReg       <= absDividend;
            divsReg      <= absDivisor;
            dividendOrig <= Dividend;
            qNeg         <= dividendNeg ^ divisorNeg;
            rNeg         <= dividendNeg;
            divZero      <= divZeroIn;
            overflow     <= overflowIn;
          end
        end
        CALC: begin
          remReg  <= stepRem;
          quoReg  <= stepQuo;
          iterCnt <= (iterCnt == LAST_ITER) ? 6'd0 : iterCnt + 6'd1;
        end
        FIX: begin
          Quotient  <= fixQuo;
          Remainder <= fixRem;
        end
        default: begin
          iterCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed RV32M vectors, latency, busy, abort-by-reset and ignored-Start checks.
module tb_seq_divider;

  logic        CLK;
  logic        RST_N;
  logic        Start;
  logic        Signed;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        busy;
  logic        done;

  seq_divider #(.WIDTH(32)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .Start    (Start),
    .Signed   (Signed),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .busy     (busy),
    .done     (done)
  );

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif
  localparam int NORMAL_LAT = 33;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] expQ[$];
  logic [31:0] expR[$];
  int          expAt[$];
  int          expLat[$];
  string       expName[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  logic [31:0] monQ, monR;
  int          monAt, monLat;
  string       monName;
  always @(negedge CLK) begin
    if (RST_N && done) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no outstanding result", cyc);
      end else begin
        monQ    = expQ.pop_front();
        monR    = expR.pop_front();
        monAt   = expAt.pop_front();
        monLat  = expLat.pop_front();
        monName = expName.pop_front();
        check({monName, "_quotient"}, Quotient, monQ);
        check({monName, "_remainder"}, Remainder, monR);
        check({monName, "_latency"}, 32'(cyc - monAt), 32'(monLat));
      end
    end
  end

  task automatic issue(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] eq, input logic [31:0] er, input int lat);
    @(negedge CLK);
    Start    = 1'b1;
    Signed   = sgn;
    Dividend = a;
    Divisor  = b;
    if (push) begin
      expQ.push_back(eq);
      expR.push_back(er);
      expAt.push_back(cyc + 1);
      expLat.push_back(lat);
      expName.push_back(name);
    end
    @(negedge CLK);
    Start    = 1'b0;
    Signed   = ~sgn;
    Dividend = $urandom;
    Divisor  = $urandom;
  endtask

  // Full transaction: issue, wait for done with busy held, then check done drops and results hold
  task automatic runOp(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input int lat, input int injectAt);
    int n;
    int busyLow;
    n       = 0;
    busyLow = 0;
    issue(name, sgn, a, b, 1'b1, eq, er, lat);
    while (n < 200) begin
      if (n == injectAt) begin
        Start    = 1'b1;
        Signed   = 1'b0;
        Dividend = 32'd9;
        Divisor  = 32'd9;
      end else begin
        Start = 1'b0;
      end
      if (done) break;
      if (!busy) busyLow++;
      @(negedge CLK);
      n++;
    end
    Start = 1'b0;
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    check({name, "_busy_low_cycles"}, 32'(busyLow), 32'd0);
    @(negedge CLK);
    check({name, "_done_single"}, {31'd0, done}, 32'd0);
    check({name, "_quotient_hold"}, Quotient, eq);
  endtask

  initial begin
    RST_N    = 1'b0;
    Start    = 1'b0;
    Signed   = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", Quotient, 32'd0);
    check("reset_remainder", Remainder, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    runOp("u100_7",     1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          NORMAL_LAT, -1);
    runOp("s_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   NORMAL_LAT, -1);
    runOp("s_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          NORMAL_LAT, -1);
    runOp("s_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   NORMAL_LAT, -1);
    runOp("dz_u",       1'b0, 32'h12345678, 32'd0,          32'hFFFFFFFF,   32'h12345678,   SPECIAL_LAT, -1);
    runOp("dz_s",       1'b1, 32'h12345678, 32'd0,          32'hFFFFFFFF,   32'h12345678,   SPECIAL_LAT, -1);
    runOp("dz_s_neg",   1'b1, 32'hFFFFFF9C, 32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C,   SPECIAL_LAT, -1);
    runOp("ovf_s",      1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          SPECIAL_LAT, -1);
    runOp("ovf_pat_u",  1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000,   NORMAL_LAT, -1);
    runOp("u_max_1",    1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0,          NORMAL_LAT, -1);
    runOp("u1000_3_ign",1'b0, 32'd1000,     32'd3,          32'd333,        32'd1,          NORMAL_LAT, 9);
    repeat (40) @(negedge CLK);

    // Abort mid-CALC; results must still show 1000/3 until reset clears them
    issue("abort", 1'b0, 32'd77, 32'd7, 1'b0, 32'd0, 32'd0, 0);
    repeat (14) @(negedge CLK);
    check("abort_quotient_stable", Quotient, 32'd333);
    check("abort_remainder_stable", Remainder, 32'd1);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    RST_N = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", Quotient, 32'd0);
    check("abort_remainder", Remainder, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_abort_busy", {31'd0, busy}, 32'd0);

    runOp("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, NORMAL_LAT, -1);
    repeat (40) @(negedge CLK);
    check("outstanding_results", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
